// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight to
// instruction memory, and holds one fetched instruction for the IF/ID register.
// A redirect squashes any fetch in flight. The response to a squashed fetch is
// dropped when it arrives.
// Optional build macro: IF_MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect target raises misalign for one cycle.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR_IF,
  output logic [31:0] PC_IF,
  output logic        fetch_bubble,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  fetch_state_t state, state_d;

  logic [31:0] pc;
  logic [31:0] pc_req;
  logic        out_valid;
  logic        accept;
  logic [31:0] redirect_aligned;

  // The low two bits are masked off so that a redirect target is always word aligned.
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign accept           = imem_req & imem_ready;
  assign fetch_bubble     = ~out_valid & ~stall;
  assign imem_addr        = pc;

  // Compute the next state and the request. A new request goes out only when the slot will be free by the time its data returns.
  always_comb begin
    state_d  = state;
    imem_req = 1'b0;
    case (state)
      S_IDLE: begin
        imem_req = ~redirect & (~out_valid | ~stall);
        if (imem_req && imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)   state_d = S_IDLE;
        else if (redirect) state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Update the PC and the output slot. A redirect wins over the returned data and over stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      IR_IF     <= NOP_WORD;
      PC_IF     <= 32'h0000_0000;
    end else if (redirect) begin
      pc        <= redirect_aligned;
      out_valid <= 1'b0;
      IR_IF     <= NOP_WORD;
    end else begin
      if (accept) begin
        pc_req <= pc;
        pc     <= pc + 32'd4;
      end
      if (state == S_WAIT && imem_rvalid) begin
        IR_IF     <= imem_rdata;
        PC_IF     <= pc_req;
        out_valid <= 1'b1;
      end else if (out_valid && !stall) begin
        out_valid <= 1'b0;
        IR_IF     <= NOP_WORD;
      end
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  // Raise misalign for one cycle after a redirect whose target is not word aligned.
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= redirect & (redirect_pc[1:0] != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

endmodule
